corescore_collector_uart: RTL and testbench
===========================================

# corescore_collector_uart

Asynchronous 8N1 UART receiver: the receive-side counterpart of the corescore UART emitter, using the same `clk_divider` bit timing. It deserialises bytes from `i_uart_rx` and presents them on a valid/ready output port. Framing errors and overruns are reported as single-cycle pulses. It sits at the FPGA RX pin and feeds a byte consumer such as a command parser or loopback checker.

## Interface
- `clk_divider`, default 12: i_clk cycles per UART bit (D); legal range ≥ 4. Let H = floor(D/2).
- `i_clk` in 1: clock; all logic on rising edge.
- `i_rst` in 1: reset, synchronous, active-low.
- `i_uart_rx` in 1: asynchronous serial line; idle high.
- `o_data` out 8: received byte; stable while `o_valid`=1.
- `o_valid` out 1: byte available.
- `i_ready` in 1: consumer accepts `o_data` when `o_valid`&`i_ready`.
- `o_frame_err` out 1: one-cycle pulse, stop bit sampled low.
- `o_overrun` out 1: one-cycle pulse, completed byte dropped because the previous byte was unconsumed.

## Operation
- Synchroniser: 2 flops on `i_uart_rx`, both reset to 1. The FSM uses only the second flop (rxs).
- Down-counter width: clog2(D)+1 bits. Shift register: 8 bits, LSB first. Bit index: 0..7.
- FSM states:
  - IDLE: on rxs=0, go to START and load cnt=H-1.
  - START: when cnt=0, sample rxs. If rxs=0, go to DATA with cnt=D-1 and bit index 0. If rxs=1, treat as a glitch and return to IDLE with no output.
  - DATA: when cnt=0, shift rxs in at bit 7 (right shift), reload cnt=D-1, and increment the index. After the 8th sample, go to STOP.
  - STOP: when cnt=0, sample rxs.
    - If 1: deliver the byte and go to IDLE. IDLE is entered mid-stop-bit, which gives the next start edge ½ bit of slack.
    - If 0: pulse `o_frame_err`, discard the byte, and go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. A line held low never produces bytes or repeated errors.
- Delivery, on the STOP success edge:
  - `o_valid`=0, or `o_valid`&`i_ready` in the same cycle: load `o_data`, set `o_valid`=1.
  - Otherwise: keep the old `o_data`/`o_valid`, drop the new byte, and pulse `o_overrun`.
- Output handshake:
  - `o_valid`&`i_ready` with no simultaneous delivery: `o_valid` clears on the next edge.
  - `o_valid` never drops without `i_ready`.
  - `o_data` changes only on a load.
- Reset values: `o_valid`=0, `o_data`=0x00, `o_frame_err`=0, `o_overrun`=0, state IDLE, cnt=0, sync flops=1.
- Reset mid-frame: the partial byte is lost. After release, reception resumes at IDLE. A line that is low at release is treated as a start bit.

## Timing
- k0 = first i_clk edge that samples `i_uart_rx`=0 at a start bit.
- rxs=0 is visible to the FSM at edge k0+2, which enters START.
- Sample edges:
  - start check: k0+2+H
  - data bit i: k0+2+H+(i+1)·D
  - stop bit: k0+2+H+9·D
- `o_valid` (or either error pulse) goes high after edge k0+2+H+9·D. For D=12 this is k0+116.
- Sustained throughput: one byte per 10·D cycles with a tolerated baud mismatch of about ±4%. Back-to-back frames from the emitter need no idle gap.
- Error pulses are exactly 1 cycle wide. They never coincide with a `o_valid` rise caused by the same frame.

## Test plan
- D=12, single frame 0xA5 starting at k0, `i_ready`=1 → `o_valid` high for exactly one cycle after edge k0+116, `o_data`=0xA5, no error pulses.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap, `i_ready`=1 → three valid beats 120 cycles apart with the correct data.
- Low glitch of 3 cycles on an idle line → FSM returns to IDLE; no `o_valid` and no error pulse.
- Frame 0x3C with stop bit forced 0, line then held low for 50 cycles, then frame 0x81 → one `o_frame_err` pulse, no byte for 0x3C, then `o_data`=0x81 valid.
- Frames 0x11, 0x22 with `i_ready`=0 → `o_data` stays 0x11 and one `o_overrun` pulse fires at the 0x22 stop sample. Then raising `i_ready` consumes 0x11 and `o_valid` drops.
- Loopback from the emitter (same D) sending 0x00–0xFF, with `i_rst` pulsed low mid-frame once → all bytes sent after reset release are received in order. Every output is at its reset value during reset.

Source files
------------

// File: rtl/corescore_collector_uart.sv
// 8N1 UART receiver with 2-flop synchroniser and valid/ready output port.
// Bit timing comes from clk_divider, which matches the corescore UART emitter.
module corescore_collector_uart #(
  parameter int clk_divider = 12
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int CW = $clog2(clk_divider) + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(clk_divider / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(clk_divider - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          rx_meta_q, rxs_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= i_uart_rx;
      rxs_q       <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (valid_q && i_ready) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = HALF_M1;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (!rxs_q) begin
            state_d = S_DATA;
            cnt_d   = FULL_M1;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rxs_q, shift_q[7:1]};
          cnt_d   = FULL_M1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          if (rxs_q) begin
            // Returning to IDLE mid-stop-bit leaves half a bit of slack for the next start edge.
            state_d = S_IDLE;
            if (!valid_q || i_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_corescore_collector_uart.sv
// Self-checking bench for corescore_collector_uart: an emitter model drives the line
// and a negedge monitor logs accepted bytes, valid rises and error pulses.
module tb_corescore_collector_uart;

  localparam int D = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;

  logic [7:0] got_q[$];
  int         rise_q[$];
  int         fe_q[$];
  int         ov_q[$];
  int         valid_hi_cnt = 0;
  int         wide_cnt = 0;
  int         viol_cnt = 0;
  int         coincide_cnt = 0;
  logic       valid_prev = 1'b0;
  logic       ready_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  logic       fe_prev = 1'b0;
  logic       ov_prev = 1'b0;
  logic       rst_prev = 1'b0;

  corescore_collector_uart #(.clk_divider(D)) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_uart_rx  (rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (ready),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: cyc at a negedge is the number of the rising edge just taken.
  always @(negedge clk) begin
    if (rst_n && rst_prev) begin
      if (valid_prev && !ready_prev && (!o_valid || o_data !== data_prev)) viol_cnt++;
      if ((o_frame_err && fe_prev) || (o_overrun && ov_prev)) wide_cnt++;
      if ((o_frame_err || o_overrun) && o_valid && !valid_prev) coincide_cnt++;
    end
    if (rst_n) begin
      if (o_valid && !valid_prev) rise_q.push_back(cyc);
      if (o_valid) valid_hi_cnt++;
      if (o_valid && ready) got_q.push_back(o_data);
      if (o_frame_err) fe_q.push_back(cyc);
      if (o_overrun) ov_q.push_back(cyc);
    end
    valid_prev = o_valid;
    ready_prev = ready;
    data_prev  = o_data;
    fe_prev    = o_frame_err;
    ov_prev    = o_overrun;
    rst_prev   = rst_n;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    rise_q.delete();
    fe_q.delete();
    ov_q.delete();
    valid_hi_cnt = 0;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(D);
  endtask

  // Emitter model: start bit, 8 data bits LSB first, stop bit; returns edge k0.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int k0);
    k0 = cyc + 1;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    tick(3);
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", o_valid); end
    checks++;
    if (o_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", o_data); end
    checks++;
    if (o_frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", o_frame_err); end
    checks++;
    if (o_overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", o_overrun); end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_single();
    int k0;
    clear_mon();
    ready = 1'b1;
    send_frame(8'hA5, 1'b1, k0);
    tick(2 * D);
    check_int("single_count", got_q.size(), 1);
    if (got_q.size() > 0) check_int("single_data", got_q[0], 8'hA5);
    if (rise_q.size() > 0) check_int("single_rise_edge", rise_q[0], k0 + 116);
    check_int("single_valid_width", valid_hi_cnt, 1);
    check_int("single_errs", fe_q.size() + ov_q.size(), 0);
  endtask

  task automatic test_back_to_back();
    int k0a, k0b, k0c;
    logic [7:0] exp[3] = '{8'h00, 8'hFF, 8'h55};
    clear_mon();
    ready = 1'b1;
    send_frame(exp[0], 1'b1, k0a);
    send_frame(exp[1], 1'b1, k0b);
    send_frame(exp[2], 1'b1, k0c);
    tick(2 * D);
    check_int("b2b_count", got_q.size(), 3);
    check_int("b2b_rises", rise_q.size(), 3);
    if (rise_q.size() == 3) begin
      check_int("b2b_first_edge", rise_q[0], k0a + 116);
      check_int("b2b_gap1", rise_q[1] - rise_q[0], 10 * D);
      check_int("b2b_gap2", rise_q[2] - rise_q[1], 10 * D);
    end
    for (int i = 0; i < 3 && i < got_q.size(); i++) check_int($sformatf("b2b_data%0d", i), got_q[i], exp[i]);
  endtask

  task automatic test_glitch();
    clear_mon();
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(200);
    check_int("glitch_bytes", rise_q.size(), 0);
    check_int("glitch_errs", fe_q.size() + ov_q.size(), 0);
  endtask

  task automatic test_frame_err();
    int k0a, k0b;
    clear_mon();
    ready = 1'b1;
    send_frame(8'h3C, 1'b0, k0a);
    rx = 1'b0;
    tick(50);
    rx = 1'b1;
    tick(D);
    send_frame(8'h81, 1'b1, k0b);
    tick(2 * D);
    check_int("ferr_pulses", fe_q.size(), 1);
    if (fe_q.size() > 0) check_int("ferr_edge", fe_q[0], k0a + 116);
    check_int("ferr_bytes", got_q.size(), 1);
    if (got_q.size() > 0) check_int("ferr_next_data", got_q[0], 8'h81);
    check_int("ferr_overrun", ov_q.size(), 0);
  endtask

  task automatic test_overrun();
    int k0a, k0b;
    clear_mon();
    ready = 1'b0;
    send_frame(8'h11, 1'b1, k0a);
    send_frame(8'h22, 1'b1, k0b);
    tick(2 * D);
    check_int("ovr_valid_held", o_valid, 1);
    check_int("ovr_data_held", o_data, 8'h11);
    check_int("ovr_pulses", ov_q.size(), 1);
    if (ov_q.size() > 0) check_int("ovr_edge", ov_q[0], k0b + 116);
    ready = 1'b1;
    tick(1);
    check_int("ovr_valid_drop", o_valid, 0);
    check_int("ovr_consumed", got_q.size(), 1);
    if (got_q.size() > 0) check_int("ovr_consumed_data", got_q[0], 8'h11);
  endtask

  task automatic test_loopback_reset();
    logic [7:0] exp_q[$];
    int k0;
    int r;
    int nb;
    clear_mon();
    r = $urandom_range(10, 245);
    rand_ready = 1'b1;
    for (int b = 0; b < 256; b++) begin
      if (b == r) begin
        rand_ready = 1'b0;
        ready = 1'b1;
        nb = $urandom_range(1, 5);
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(b[i]);
        rst_n = 1'b0;
        rx = 1'b1;
        tick(1);
        check_int("lb_rst_valid", o_valid, 0);
        check_int("lb_rst_data", o_data, 0);
        check_int("lb_rst_errs", o_frame_err + o_overrun, 0);
        tick(3);
        rst_n = 1'b1;
        tick(D);
        rand_ready = 1'b1;
      end else begin
        send_frame(8'(b), 1'b1, k0);
        exp_q.push_back(8'(b));
        rx = 1'b1;
        tick($urandom_range(0, D));
      end
    end
    rand_ready = 1'b0;
    ready = 1'b1;
    tick(3 * D);
    check_int("lb_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_int($sformatf("lb_data%0d", i), got_q[i], exp_q[i]);
    check_int("lb_errs", fe_q.size() + ov_q.size(), 0);
  endtask

  task automatic test_protocol();
    check_int("proto_hold_violations", viol_cnt, 0);
    check_int("proto_wide_pulses", wide_cnt, 0);
    check_int("proto_err_with_valid", coincide_cnt, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_loopback_reset();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
